// File: rtl/mcc_pkg.sv
// rtl/mcc_pkg.sv - shared types and constants for the nibble-serial subtractor
package mcc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int slice_count(input int size);
        return size / SLICE_W;
    endfunction

endpackage

// File: rtl/mcc_borrow_slice4.sv
// rtl/mcc_borrow_slice4.sv - combinational 4-bit Manchester carry chain in complement-add form
module mcc_borrow_slice4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] c;

    // Each stage either generates, passes the incoming carry (p), or kills it.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign d    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/mcc_subtractor_seq.sv
// rtl/mcc_subtractor_seq.sv - nibble-serial a-b-bin subtractor with valid/ready handshakes
module mcc_subtractor_seq
    import mcc_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bout
);

    localparam int NSL = slice_count(SIZE);
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

    state_t          state;
    logic [SIZE-1:0] a_r;
    logic [SIZE-1:0] b_r;
    logic [SIZE-1:0] diff_r;
    logic            bout_r;
    logic [KW-1:0]   k;
    logic            carry;

    logic [3:0] a_sl;
    logic [3:0] b_sl;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] d;
    logic       cout;

    // Current slice is selected by shifting down by 4*k.
    always_comb begin
        a_sl = 4'(a_r >> {k, 2'b00});
        b_sl = 4'(b_r >> {k, 2'b00});
        p    = a_sl ^ ~b_sl;
        g    = a_sl & ~b_sl;
    end

    mcc_borrow_slice4 u_slice (
        .p    (p),
        .g    (g),
        .cin  (carry),
        .d    (d),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            k      <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        carry  <= ~bin;
                        k      <= '0;
                        diff_r <= '0;
                        bout_r <= 1'b0;
                        state  <= PRE;
                    end
                end
                PRE: begin
                    state <= EVAL;
                end
                EVAL: begin
                    // Unevaluated slices are still zero, so OR-ing in the new slice is exact.
                    diff_r <= diff_r | (SIZE'(d) << {k, 2'b00});
                    carry  <= cout;
                    if (k == K_LAST) begin
                        bout_r <= ~cout;
                        state  <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= PRE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule
